aes32_inv_shiftrows_stream: RTL and testbench
=============================================

// Module: aes32_inv_shiftrows_stream
// PURPOSE
//  Word-serial AES InvShiftRows stage for the decrypt datapath; inverse of the parallel ShiftRows column shuffle.
//  Accepts a 128-bit state as four 32-bit column words (col0..col3, byte[31:24]=row0) over a valid/ready stream.
//  Buffers each block and emits the four inverse-shifted column words on a valid/ready stream.
//  Sits between the decrypt key-add stage and the InvSubBytes stage.
// PARAMETERS
//  BANKS   2   block buffers: 1 = fill then drain, 8 cyc/block; 2 = ping-pong, 1 word/cyc sustained
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  in_word    in   32  input column word; arrival order col0,col1,col2,col3
//  in_valid   in   1   in_word valid
//  in_ready   out  1   block accepts in_word this cycle
//  out_word   out  32  InvShiftRows column word; order col0..col3
//  out_valid  out  1   out_word valid
//  out_ready  in   1   downstream accepts out_word
//  out_last   out  1   high with out_word of col3
// BEHAVIOUR
//  - Handshakes: a word transfers on a cycle where valid&&ready are both high. out_word, out_valid and out_last stay stable
//    while out_valid && !out_ready. in_ready does not depend combinationally on in_valid.
//  - Reset: out_valid=0, out_last=0, out_word=0, in_ready=0 in the reset cycle and 1 from the next cycle.
//    Write/read counters and both bank states clear. Partial blocks are discarded. Reset mid-drain drops the remaining words.
//  - Per bank: state EMPTY -> FILLING (first word in) -> FULL (col3 written) -> DRAINING -> EMPTY (col3 accepted).
//    Banks fill and drain round-robin. 2-bit write index and read index wrap 3->0 at the block boundary.
//  - in_ready = 1 when the write bank is EMPTY or FILLING. out_valid = 1 when the read bank is FULL or DRAINING.
//  - Latency: col0 is presented on out_word the cycle after col3 is accepted.
//    BANKS=2: a write to one bank and a read from the other in the same cycle are legal. No bubble at either
//    full or empty bank boundaries.
//  - BANKS=1: in_ready=0 from col3 accepted until out col3 accepted. in_ready=1 in the cycle after the last output.
//  - Mapping: d0..d3 = stored col0..col3. Output byte row r of column j comes from input column (j-r) mod 4:
//      o0={d0[31:24],d3[23:16],d2[15:8],d1[7:0]}   o1={d1[31:24],d0[23:16],d3[15:8],d2[7:0]}
//      o2={d2[31:24],d1[23:16],d0[15:8],d3[7:0]}   o3={d3[31:24],d2[23:16],d1[15:8],d0[7:0]}
//  - No arithmetic; pure byte routing from the registered bank. out_word is muxed from the bank by the read index.
//  - in_valid while in_ready=0: ignored, the word is not captured, and no counter moves.
//  - Backpressure on output, any length: bank stays DRAINING. With BANKS=2 the other bank fills, then in_ready drops.
// CONFIGURATION
//  AES32_INVSR_BYPASS_EN defined:
//    - Adds port `bypass in 1`, sampled with the col0 input handshake and held per block.
//    - When the sampled value is 1, that block is emitted unshuffled: o_j = d_j.
//  AES32_INVSR_BYPASS_EN undefined: no bypass port; every block is inverse-shifted.
// TESTING
//  1. Reset, then stream 00010203,04050607,08090a0b,0c0d0e0f with out_ready=1
//     -> out 000d0a07,04010e0b,0805020f,0c090603; out_last on the 4th word; first out 1 cycle after the 4th in.
//  2. BANKS=2, three back-to-back blocks, out_ready=1 -> in_ready stays 1, out_valid is continuous, 12 words are correct.
//  3. out_ready=0 for 10 cycles mid-block -> out_word is held stable. BANKS=2: in_ready drops after the second block fills.
//     Resume -> no loss or duplication.
//  4. Assert rst after 2 input words, then send a fresh block -> only the fresh block's 4 words appear, correctly mapped.
//  5. BANKS=1, two blocks -> in_ready=0 during the drain; second block accepted after out col3; both blocks correct.
//  6. Bypass macro on, bypass=1 with col0 of the block from test 1 -> out 00010203,04050607,08090a0b,0c0d0e0f.
//     A following block with bypass=0 is shifted.

Source files
------------

// File: rtl/aes32_inv_shiftrows_stream_if.sv
// Stream bundle for the word-serial AES InvShiftRows stage.
// slave: DUT side (in_* consumer, out_* producer); master: driver/monitor side.
// Optional bypass signal exists only when AES32_INVSR_BYPASS_EN is defined.
interface aes32_inv_shiftrows_stream_if;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
`ifdef AES32_INVSR_BYPASS_EN
    logic        bypass;

    modport slave (
        input  in_word, in_valid, out_ready, bypass,
        output in_ready, out_word, out_valid, out_last
    );
    modport master (
        output in_word, in_valid, out_ready, bypass,
        input  in_ready, out_word, out_valid, out_last
    );
`else
    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_word, out_valid, out_last
    );
    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_word, out_valid, out_last
    );
`endif
endinterface

// File: rtl/aes32_inv_shiftrows_stream.sv
// Word-serial AES InvShiftRows: buffers four column words per block and
// emits the inverse-shifted columns col0..col3 on a valid/ready stream.
// Ports: clk, rst (sync, active-high), io (slave modport: in_word/in_valid/
// in_ready, out_word/out_valid/out_ready/out_last, optional bypass).
// Parameter BANKS: 1 = fill-then-drain, 2 = ping-pong buffering.
// Macro AES32_INVSR_BYPASS_EN adds a per-block bypass (unshuffled output).
module aes32_inv_shiftrows_stream #(
    parameter int BANKS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    aes32_inv_shiftrows_stream_if.slave   io
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL,
        ST_DRAINING
    } bank_st_e;

    // Bank toggling is disabled with a single bank, so bank 1 stays idle.
    localparam logic MULTI = 1'(BANKS == 2);

    bank_st_e    st_q [2];
    bank_st_e    st_d [2];
    logic [31:0] mem_q [2][4];
    logic [31:0] mem_d [2][4];
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic [1:0]  wr_idx_q, wr_idx_d;
    logic [1:0]  rd_idx_q, rd_idx_d;
`ifdef AES32_INVSR_BYPASS_EN
    logic        byp_q [2];
    logic        byp_d [2];
`endif

    logic        in_ready;
    logic        out_valid;
    logic        wr_fire;
    logic        rd_fire;
    logic [31:0] shuf;
    logic [1:0]  src;

    // Handshake status depends only on registered bank state.
    always_comb begin
        in_ready  = !rst && (st_q[wr_bank_q] == ST_EMPTY ||
                             st_q[wr_bank_q] == ST_FILLING);
        out_valid = !rst && (st_q[rd_bank_q] == ST_FULL ||
                             st_q[rd_bank_q] == ST_DRAINING);
        wr_fire   = io.in_valid && in_ready;
        rd_fire   = out_valid && io.out_ready;
    end

    // Row r of output column j is taken from stored column (j - r) mod 4.
    always_comb begin
        shuf = '0;
        src  = '0;
        for (int r = 0; r < 4; r++) begin
            src = rd_idx_q - 2'(r);
            shuf[31-8*r -: 8] = mem_q[rd_bank_q][src][31-8*r -: 8];
        end
`ifdef AES32_INVSR_BYPASS_EN
        if (byp_q[rd_bank_q]) begin
            shuf = mem_q[rd_bank_q][rd_idx_q];
        end
`endif
        io.in_ready  = in_ready;
        io.out_valid = out_valid;
        io.out_word  = out_valid ? shuf : '0;
        io.out_last  = out_valid && (rd_idx_q == 2'd3);
    end

    // Write and read never target the same bank in one cycle: a writable
    // bank is EMPTY/FILLING, a readable one is FULL/DRAINING.
    always_comb begin
        st_d      = st_q;
        mem_d     = mem_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
`ifdef AES32_INVSR_BYPASS_EN
        byp_d     = byp_q;
`endif
        if (wr_fire) begin
            mem_d[wr_bank_q][wr_idx_q] = io.in_word;
            st_d[wr_bank_q] = (wr_idx_q == 2'd3) ? ST_FULL : ST_FILLING;
            wr_idx_d = wr_idx_q + 2'd1;
            if (wr_idx_q == 2'd3) begin
                wr_bank_d = MULTI & ~wr_bank_q;
            end
`ifdef AES32_INVSR_BYPASS_EN
            if (wr_idx_q == 2'd0) begin
                byp_d[wr_bank_q] = io.bypass;
            end
`endif
        end
        if (rd_fire) begin
            st_d[rd_bank_q] = (rd_idx_q == 2'd3) ? ST_EMPTY : ST_DRAINING;
            rd_idx_d = rd_idx_q + 2'd1;
            if (rd_idx_q == 2'd3) begin
                rd_bank_d = MULTI & ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0]   <= ST_EMPTY;
            st_q[1]   <= ST_EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= 2'd0;
            rd_idx_q  <= 2'd0;
`ifdef AES32_INVSR_BYPASS_EN
            byp_q[0]  <= 1'b0;
            byp_q[1]  <= 1'b0;
`endif
        end else begin
            st_q      <= st_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
`ifdef AES32_INVSR_BYPASS_EN
            byp_q     <= byp_d;
`endif
        end
    end

    // Data storage needs no reset; validity is tracked by bank state.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_aes32_inv_shiftrows_stream.sv
// Self-checking bench for aes32_inv_shiftrows_stream (BANKS=2 and BANKS=1).
// Directed blocks with hand-computed InvShiftRows results.
module tb_aes32_inv_shiftrows_stream;

    typedef logic [31:0] blk_t [4];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    aes32_inv_shiftrows_stream_if b2 ();
    aes32_inv_shiftrows_stream_if b1 ();

    aes32_inv_shiftrows_stream #(.BANKS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .io  (b2)
    );

    aes32_inv_shiftrows_stream #(.BANKS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .io  (b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    blk_t in_a  = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    blk_t out_a = '{32'h000d0a07, 32'h04010e0b, 32'h0805020f, 32'h0c090603};
    blk_t in_b  = '{32'h11223344, 32'h55667788, 32'h99aabbcc, 32'hddeeff00};
    blk_t out_b = '{32'h11eebb88, 32'h5522ffcc, 32'h99663300, 32'hddaa7744};
    blk_t in_c  = '{32'h10203040, 32'h50607080, 32'h90a0b0c0, 32'hd0e0f000};
    blk_t out_c = '{32'h10e0b080, 32'h5020f0c0, 32'h90603000, 32'hd0a07040};

    logic [31:0] exp2 [$];
    logic [31:0] exp1 [$];
    int got2 = 0;
    int got1 = 0;
    int first2 = -1;
    int last2 = -1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitors: compare every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (b2.out_valid && b2.out_ready) begin
            if (exp2.size() == 0) begin
                check("unexp2", 32'(exp2.size()), 32'd1);
            end else begin
                check("word2", b2.out_word, exp2.pop_front());
                check("last2", 32'(b2.out_last), 32'(got2 % 4 == 3));
            end
            got2++;
            if (first2 < 0) first2 = cyc;
            last2 = cyc;
        end
        if (b1.out_valid && b1.out_ready) begin
            if (exp1.size() == 0) begin
                check("unexp1", 32'(exp1.size()), 32'd1);
            end else begin
                check("word1", b1.out_word, exp1.pop_front());
                check("last1", 32'(b1.out_last), 32'(got1 % 4 == 3));
            end
            got1++;
        end
    end

    task automatic drive(input int sel, input logic v, input logic [31:0] w,
                         input logic byp);
        if (sel == 1) begin
            b1.in_valid = v;
            b1.in_word  = w;
        end else begin
            b2.in_valid = v;
            b2.in_word  = w;
`ifdef AES32_INVSR_BYPASS_EN
            b2.bypass   = byp;
`else
            if (byp) b2.in_word = w;
`endif
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 1) ? b1.in_ready : b2.in_ready;
    endfunction

    task automatic push(input int sel, input blk_t v);
        for (int i = 0; i < 4; i++) begin
            if (sel == 1) exp1.push_back(v[i]);
            else          exp2.push_back(v[i]);
        end
    endtask

    task automatic send(input int sel, input blk_t w, input logic byp,
                        output int stalls);
        int  tmo;
        bit  ok;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            tmo = 0;
            ok  = 1'b0;
            drive(sel, 1'b1, w[i], byp);
            while (!ok && tmo < 200) begin
                @(negedge clk);
                if (rdy(sel)) ok = 1'b1;
                else begin
                    stalls++;
                    tmo++;
                end
            end
            if (!ok) check("send_tmo", 32'(tmo), 32'd0);
            @(posedge clk);
            #1;
        end
        drive(sel, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic drain(input int sel);
        int t;
        t = 0;
        while (((sel == 1) ? exp1.size() : exp2.size()) != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("drain", 32'((sel == 1) ? exp1.size() : exp2.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int tot;
        b2.in_valid = 1'b0;
        b2.in_word = '0;
        b2.out_ready = 1'b0;
        b1.in_valid = 1'b0;
        b1.in_word = '0;
        b1.out_ready = 1'b0;
`ifdef AES32_INVSR_BYPASS_EN
        b2.bypass = 1'b0;
        b1.bypass = 1'b0;
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready2", 32'(b2.in_ready), 32'd0);
        check("rst_out_valid2", 32'(b2.out_valid), 32'd0);
        check("rst_out_word2", b2.out_word, 32'd0);
        check("rst_out_last2", 32'(b2.out_last), 32'd0);
        check("rst_in_ready1", 32'(b1.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready2", 32'(b2.in_ready), 32'd1);
        check("post_rst_in_ready1", 32'(b1.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single block, latency check.
        b2.out_ready = 1'b1;
        push(2, out_a);
        send(2, in_a, 1'b0, s);
        @(negedge clk);
        check("t1_lat_valid", 32'(b2.out_valid), 32'd1);
        check("t1_lat_word", b2.out_word, 32'h000d0a07);
        drain(2);

        // Three back-to-back blocks through the ping-pong buffer.
        first2 = -1;
        push(2, out_a);
        push(2, out_b);
        push(2, out_c);
        tot = 0;
        send(2, in_a, 1'b0, s);
        tot += s;
        send(2, in_b, 1'b0, s);
        tot += s;
        send(2, in_c, 1'b0, s);
        tot += s;
        drain(2);
        check("t2_stalls", 32'(tot), 32'd0);
        check("t2_span", 32'(last2 - first2), 32'd11);

        // Output backpressure mid-block.
        b2.out_ready = 1'b0;
        push(2, out_a);
        push(2, out_b);
        push(2, out_c);
        send(2, in_a, 1'b0, s);
        b2.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        b2.out_ready = 1'b0;
        send(2, in_b, 1'b0, s);
        check("t3_b_stalls", 32'(s), 32'd0);
        drive(2, 1'b1, in_c[0], 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_hold_word", b2.out_word, 32'h0805020f);
            check("t3_in_ready", 32'(b2.in_ready), 32'd0);
        end
        check("t3_hold_last", 32'(b2.out_last), 32'd0);
        check("t3_hold_valid", 32'(b2.out_valid), 32'd1);
        @(posedge clk);
        #1;
        b2.out_ready = 1'b1;
        send(2, in_c, 1'b0, s);
        drain(2);

        // Reset with a partial block in flight.
        drive(2, 1'b1, in_a[0], 1'b0);
        @(posedge clk);
        #1;
        drive(2, 1'b1, in_a[1], 1'b0);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_valid", 32'(b2.out_valid), 32'd0);
        check("t4_rst_ready", 32'(b2.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(2, out_b);
        send(2, in_b, 1'b0, s);
        drain(2);

        // Single-bank instance: fill then drain.
        b1.out_ready = 1'b1;
        push(1, out_a);
        push(1, out_b);
        send(1, in_a, 1'b0, s);
        check("t5_a_stalls", 32'(s), 32'd0);
        send(1, in_b, 1'b0, s);
        check("t5_b_stalls", 32'(s), 32'd4);
        drain(1);
        check("t5_count", 32'(got1), 32'd8);

`ifdef AES32_INVSR_BYPASS_EN
        // Bypassed block followed by a shifted one.
        push(2, in_a);
        push(2, out_b);
        send(2, in_a, 1'b1, s);
        send(2, in_b, 1'b0, s);
        drain(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
